// File: rtl/pixel_framebuffer_vga_if.sv
// rtl/pixel_framebuffer_vga_if.sv - pixel-write stream from the drawing engines
//
// Purpose: carries one pixel write per cycle into the frame buffer.
// Signals:
//   plot  - write strobe, one pixel per cycle while high
//   x     - write column (8 bits)
//   y     - write row (7 bits)
//   color - {R,G,B} write data
// Modports: master drives the stream (drawing engine / bench), slave receives it.
interface pixel_framebuffer_vga_if;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;

    modport master (output plot, x, y, color);
    modport slave  (input  plot, x, y, color);
endinterface

// File: rtl/pixel_framebuffer_vga.sv
// rtl/pixel_framebuffer_vga.sv - 3-bit frame buffer scanned out as a 4x scaled VGA raster
//
// Purpose: stores pixel writes in an FB_W x FB_H x 3-bit dual-port RAM and
// continuously scans it out as an H_VISIBLE x V_VISIBLE raster, each stored
// pixel replicated into a 4x4 block. Two-stage scan pipeline; sync/enable
// are delayed to stay aligned with the colour outputs.
// Ports:
//   clk          - pixel clock, one screen pixel per rising edge
//   reset_n      - asynchronous active-low reset
//   wr           - pixel-write stream (plot, x, y, color), slave side
//   vga_r/g/b    - 8-bit colour outputs, zero outside the visible area
//   vga_hs/vs    - active-low syncs
//   vga_de       - high in the visible area
//   frame_start  - one-cycle pulse on output pixel (0,0)
//   wr_dropped   - registered pulse the cycle after an out-of-range plot
module pixel_framebuffer_vga #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int FB_W      = 160,
    parameter int FB_H      = 120
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pixel_framebuffer_vga_if.slave  wr,
    output logic [7:0]              vga_r,
    output logic [7:0]              vga_g,
    output logic [7:0]              vga_b,
    output logic                    vga_hs,
    output logic                    vga_vs,
    output logic                    vga_de,
    output logic                    frame_start,
    output logic                    wr_dropped
);

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int DEPTH    = FB_W * FB_H;
    localparam int AW       = $clog2(DEPTH);
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    // row*FB_W + col built from shifted copies of row, one per set bit of
    // FB_W; for FB_W=160 this is (row<<7)+(row<<5)+col, no multiplier.
    function automatic logic [AW-1:0] fb_addr(input logic [6:0] row, input logic [7:0] col);
        logic [AW+7:0] acc;
        acc = (AW+8)'(col);
        for (int i = 0; i < 16; i++) begin
            if (FB_W[i]) acc = acc + ((AW+8)'(row) << i);
        end
        return acc[AW-1:0];
    endfunction

    // ---------------- write port ----------------
    logic          w_wr_in_range;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;

    // Range check gates the write so out-of-range coordinates never alias.
    assign w_wr_in_range = (32'(wr.x) < FB_W) && (32'(wr.y) < FB_H);
    assign w_wr_en       = wr.plot && w_wr_in_range;
    assign w_wr_addr     = fb_addr(wr.y, wr.x);

    // ---------------- scan counters ----------------
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_h_end;
    logic          w_v_end;

    assign w_h_end = (r_h_cnt == HW'(H_TOTAL - 1));
    assign w_v_end = (r_v_cnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_end ? '0 : r_h_cnt + 1'b1;
            if (w_h_end) r_v_cnt <= w_v_end ? '0 : r_v_cnt + 1'b1;
        end
    end

    logic          w_vis;
    logic          w_hs_n;
    logic          w_vs_n;
    logic          w_origin;
    logic [AW-1:0] w_rd_addr;

    assign w_vis    = (32'(r_h_cnt) < H_VISIBLE) && (32'(r_v_cnt) < V_VISIBLE);
    assign w_hs_n   = !((32'(r_h_cnt) >= HS_START) && (32'(r_h_cnt) < HS_END));
    assign w_vs_n   = !((32'(r_v_cnt) >= VS_START) && (32'(r_v_cnt) < VS_END));
    assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
    // Blanking reads are parked on address 0; their data is masked anyway.
    assign w_rd_addr = w_vis ? fb_addr(7'(r_v_cnt >> 2), 8'(r_h_cnt >> 2)) : '0;

    // ---------------- frame buffer RAM ----------------
    // Not reset: contents survive reset. Non-blocking read and write in one
    // process give read-before-write on a same-address collision.
    logic [2:0] r_fb [DEPTH];
    logic [2:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (w_wr_en) r_fb[w_wr_addr] <= wr.color;
        r_rd_data <= r_fb[w_rd_addr];
    end

    // ---------------- stage 1: timing aligned with RAM read ----------------
    logic r_de1, r_hs1, r_vs1, r_fs1;
    logic r_wr_dropped;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_de1        <= 1'b0;
            r_hs1        <= 1'b1;
            r_vs1        <= 1'b1;
            r_fs1        <= 1'b0;
            r_wr_dropped <= 1'b0;
        end else begin
            r_de1        <= w_vis;
            r_hs1        <= w_hs_n;
            r_vs1        <= w_vs_n;
            r_fs1        <= w_origin;
            r_wr_dropped <= wr.plot && !w_wr_in_range;
        end
    end

    // ---------------- stage 2: colour expansion ----------------
    logic [7:0] r_red, r_grn, r_blu;
    logic       r_de2, r_hs2, r_vs2, r_fs2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_red <= 8'h00;
            r_grn <= 8'h00;
            r_blu <= 8'h00;
            r_de2 <= 1'b0;
            r_hs2 <= 1'b1;
            r_vs2 <= 1'b1;
            r_fs2 <= 1'b0;
        end else begin
            r_red <= r_de1 ? {8{r_rd_data[2]}} : 8'h00;
            r_grn <= r_de1 ? {8{r_rd_data[1]}} : 8'h00;
            r_blu <= r_de1 ? {8{r_rd_data[0]}} : 8'h00;
            r_de2 <= r_de1;
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
            r_fs2 <= r_fs1;
        end
    end

    assign vga_r       = r_red;
    assign vga_g       = r_grn;
    assign vga_b       = r_blu;
    assign vga_de      = r_de2;
    assign vga_hs      = r_hs2;
    assign vga_vs      = r_vs2;
    assign frame_start = r_fs2;
    assign wr_dropped  = r_wr_dropped;

endmodule
